// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: tracks E/M/W destinations
// and latencies, raising the D-stage stall and per-stage forward selects.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_A1,
  input  logic [4:0]       D_A2,
  input  logic [1:0]       D_Tuse1,
  input  logic [1:0]       D_Tuse2,
  input  logic [4:0]       D_A3,
  input  logic [1:0]       D_Tnew,
  output logic             stall,
  output logic [1:0]       D_fwd1,
  output logic [1:0]       D_fwd2,
  output logic [1:0]       E_fwd1,
  output logic [1:0]       E_fwd2,
  output logic [1:0]       M_fwd2,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_E    = 2'd1;
  localparam logic [1:0] SEL_M    = 2'd2;
  localparam logic [1:0] SEL_W    = 2'd3;

  logic [4:0]       e_a1_q, e_a1_d;
  logic [4:0]       e_a2_q, e_a2_d;
  logic [4:0]       e_a3_q, e_a3_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic [4:0]       m_a2_q, m_a2_d;
  logic [4:0]       m_a3_q, m_a3_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       w_a3_q, w_a3_d;
  logic [1:0]       w_tnew_q, w_tnew_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_rs;
  logic stall_rt;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic src_ok(
    input logic [4:0] a,
    input logic [4:0] a3,
    input logic [1:0] tnew
  );
    return (a != 5'd0) && (a3 == a) && (tnew == 2'd0);
  endfunction

  function automatic logic need_stall(
    input logic [4:0] a,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic [1:0] tnew
  );
    return (a != 5'd0) && (a3 == a) && (tuse < tnew);
  endfunction

  // Only E and M can still owe a result; W latency is always zero.
  always_comb begin
    stall_rs = need_stall(D_A1, D_Tuse1, e_a3_q, e_tnew_q)
             | need_stall(D_A1, D_Tuse1, m_a3_q, m_tnew_q);
    stall_rt = need_stall(D_A2, D_Tuse2, e_a3_q, e_tnew_q)
             | need_stall(D_A2, D_Tuse2, m_a3_q, m_tnew_q);
    stall    = stall_rs | stall_rt;
  end

  always_comb begin
    D_fwd1 = SEL_NONE;
    if (src_ok(D_A1, e_a3_q, e_tnew_q))
      D_fwd1 = SEL_E;
    else if (src_ok(D_A1, m_a3_q, m_tnew_q))
      D_fwd1 = SEL_M;
    else if (src_ok(D_A1, w_a3_q, w_tnew_q))
      D_fwd1 = SEL_W;
  end

  always_comb begin
    D_fwd2 = SEL_NONE;
    if (src_ok(D_A2, e_a3_q, e_tnew_q))
      D_fwd2 = SEL_E;
    else if (src_ok(D_A2, m_a3_q, m_tnew_q))
      D_fwd2 = SEL_M;
    else if (src_ok(D_A2, w_a3_q, w_tnew_q))
      D_fwd2 = SEL_W;
  end

  always_comb begin
    E_fwd1 = SEL_NONE;
    if (src_ok(e_a1_q, m_a3_q, m_tnew_q))
      E_fwd1 = SEL_M;
    else if (src_ok(e_a1_q, w_a3_q, w_tnew_q))
      E_fwd1 = SEL_W;
  end

  always_comb begin
    E_fwd2 = SEL_NONE;
    if (src_ok(e_a2_q, m_a3_q, m_tnew_q))
      E_fwd2 = SEL_M;
    else if (src_ok(e_a2_q, w_a3_q, w_tnew_q))
      E_fwd2 = SEL_W;
  end

  always_comb begin
    M_fwd2 = SEL_NONE;
    if (src_ok(m_a2_q, w_a3_q, w_tnew_q))
      M_fwd2 = SEL_W;
  end

  // A stall turns the E slot into a bubble while M and W keep draining.
  always_comb begin
    e_a1_d   = D_A1;
    e_a2_d   = D_A2;
    e_a3_d   = D_A3;
    e_tnew_d = dec_sat(D_Tnew);
    if (stall) begin
      e_a1_d   = 5'd0;
      e_a2_d   = 5'd0;
      e_a3_d   = 5'd0;
      e_tnew_d = 2'd0;
    end
    m_a2_d   = e_a2_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = dec_sat(e_tnew_q);
    w_a3_d   = m_a3_q;
    w_tnew_d = dec_sat(m_tnew_q);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a1_q   <= 5'd0;
      e_a2_q   <= 5'd0;
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a2_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
      w_tnew_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a2_q   <= m_a2_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed stalls, forward
// selects and stall-counter values for the classic hazard cases.
module tb_hazard_ctrl;

  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic [4:0]    D_A1, D_A2, D_A3;
  logic [1:0]    D_Tuse1, D_Tuse2, D_Tnew;
  logic          stall;
  logic [1:0]    D_fwd1, D_fwd2, E_fwd1, E_fwd2, M_fwd2;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2),
    .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
    .D_A3(D_A3), .D_Tnew(D_Tnew),
    .stall(stall),
    .D_fwd1(D_fwd1), .D_fwd2(D_fwd2),
    .E_fwd1(E_fwd1), .E_fwd2(E_fwd2),
    .M_fwd2(M_fwd2),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [1:0] u1, input logic [1:0] u2,
                       input logic [4:0] a3, input logic [1:0] tn);
    D_A1 = a1; D_A2 = a2; D_Tuse1 = u1; D_Tuse2 = u2;
    D_A3 = a3; D_Tnew = tn;
    #1;
  endtask

  task automatic flush();
    set_d(0, 0, 3, 3, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
          5'($urandom), 2'($urandom));
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (stall !== 1'b0) begin
        n_bad++; $display("FAIL rst_stall got %0d want 0", stall);
      end
      n_cmp++;
      if ({D_fwd1, D_fwd2, E_fwd1, E_fwd2, M_fwd2} !== 10'd0) begin
        n_bad++;
        $display("FAIL rst_fwd got %h want 0",
                 {D_fwd1, D_fwd2, E_fwd1, E_fwd2, M_fwd2});
      end
      n_cmp++;
      if (stall_cnt !== 3'd0) begin
        n_bad++; $display("FAIL rst_cnt got %0d want 0", stall_cnt);
      end
      set_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
            5'($urandom), 2'($urandom));
      if (k == 0) tick();
    end
    reset = 1'b0;
    flush();
  endtask

  // addu $3 then sw $3,0($3): M->E forward, then W->M store data.
  task automatic test_alu_alu();
    set_d(0, 0, 3, 3, 3, 2);
    tick();
    set_d(3, 3, 1, 2, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL alu_stall got %0d want 0", stall);
    end
    n_cmp++;
    if (D_fwd1 !== 2'd0) begin
      n_bad++; $display("FAIL alu_dfwd1 got %0d want 0", D_fwd1);
    end
    tick();
    set_d(0, 0, 3, 3, 0, 0);
    n_cmp++;
    if (E_fwd1 !== 2'd2) begin
      n_bad++; $display("FAIL alu_efwd1 got %0d want 2", E_fwd1);
    end
    n_cmp++;
    if (E_fwd2 !== 2'd2) begin
      n_bad++; $display("FAIL alu_efwd2 got %0d want 2", E_fwd2);
    end
    tick();
    n_cmp++;
    if (M_fwd2 !== 2'd3) begin
      n_bad++; $display("FAIL alu_mfwd2 got %0d want 3", M_fwd2);
    end
    flush();
  endtask

  // lw $5 then beq $5: two stall cycles, then W forward.
  task automatic load_use(input int c0, input int sat_max);
    int exp1, exp2;
    exp1 = (c0 + 1 > sat_max) ? sat_max : c0 + 1;
    exp2 = (c0 + 2 > sat_max) ? sat_max : c0 + 2;
    set_d(0, 0, 3, 3, 5, 3);
    tick();
    set_d(5, 0, 0, 3, 0, 0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall0 got %0d want 1", stall);
    end
    tick();
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall1 got %0d want 1", stall);
    end
    n_cmp++;
    if (int'(stall_cnt) !== exp1) begin
      n_bad++; $display("FAIL lu_cnt1 got %0d want %0d", stall_cnt, exp1);
    end
    tick();
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL lu_stall2 got %0d want 0", stall);
    end
    n_cmp++;
    if (D_fwd1 !== 2'd3) begin
      n_bad++; $display("FAIL lu_dfwd1 got %0d want 3", D_fwd1);
    end
    n_cmp++;
    if (int'(stall_cnt) !== exp2) begin
      n_bad++; $display("FAIL lu_cnt2 got %0d want %0d", stall_cnt, exp2);
    end
    flush();
  endtask

  task automatic test_load_use();
    load_use(0, 7);
  endtask

  task automatic test_load_store();
    set_d(0, 0, 3, 3, 4, 3);
    tick();
    set_d(0, 4, 3, 2, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL ls_stall got %0d want 0", stall);
    end
    tick();
    set_d(0, 0, 3, 3, 0, 0);
    n_cmp++;
    if (E_fwd2 !== 2'd0) begin
      n_bad++; $display("FAIL ls_efwd2 got %0d want 0", E_fwd2);
    end
    tick();
    n_cmp++;
    if (M_fwd2 !== 2'd3) begin
      n_bad++; $display("FAIL ls_mfwd2 got %0d want 3", M_fwd2);
    end
    flush();
  endtask

  task automatic test_jal_jr();
    set_d(0, 0, 3, 3, 31, 1);
    tick();
    set_d(31, 0, 0, 3, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL jr_stall got %0d want 0", stall);
    end
    n_cmp++;
    if (D_fwd1 !== 2'd1) begin
      n_bad++; $display("FAIL jr_dfwd1 got %0d want 1", D_fwd1);
    end
    flush();
  endtask

  task automatic test_priority();
    set_d(0, 0, 3, 3, 7, 1);
    tick();
    set_d(0, 0, 3, 3, 7, 1);
    tick();
    set_d(7, 7, 0, 0, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL pri_stall got %0d want 0", stall);
    end
    n_cmp++;
    if (D_fwd1 !== 2'd1) begin
      n_bad++; $display("FAIL pri_dfwd1 got %0d want 1", D_fwd1);
    end
    n_cmp++;
    if (D_fwd2 !== 2'd1) begin
      n_bad++; $display("FAIL pri_dfwd2 got %0d want 1", D_fwd2);
    end
    set_d(0, 0, 3, 3, 0, 0);
    tick();
    set_d(7, 0, 0, 3, 0, 0);
    n_cmp++;
    if (D_fwd1 !== 2'd2) begin
      n_bad++; $display("FAIL pri_m_over_w got %0d want 2", D_fwd1);
    end
    flush();
  endtask

  task automatic test_zero();
    set_d(0, 0, 3, 3, 0, 3);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL zero_stall got %0d want 0", stall);
    end
    n_cmp++;
    if ({D_fwd1, D_fwd2} !== 4'd0) begin
      n_bad++; $display("FAIL zero_dfwd got %h want 0", {D_fwd1, D_fwd2});
    end
    tick();
    n_cmp++;
    if ({E_fwd1, E_fwd2} !== 4'd0) begin
      n_bad++; $display("FAIL zero_efwd got %h want 0", {E_fwd1, E_fwd2});
    end
    flush();
  endtask

  task automatic test_reset_mid_stall();
    set_d(0, 0, 3, 3, 5, 3);
    tick();
    set_d(5, 0, 0, 3, 0, 0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL rms_pre got %0d want 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL rms_stall got %0d want 0", stall);
    end
    n_cmp++;
    if (stall_cnt !== 3'd0) begin
      n_bad++; $display("FAIL rms_cnt got %0d want 0", stall_cnt);
    end
    flush();
  endtask

  // 3-bit counter: five load-use pairs drive it past 7.
  task automatic test_saturation();
    for (int k = 0; k < 5; k++)
      load_use(2 * k, 7);
  endtask

  initial begin
    reset = 1'b0;
    set_d(0, 0, 3, 3, 0, 0);
    test_reset();
    test_alu_alu();
    test_load_use();
    test_load_store();
    test_jal_jr();
    test_priority();
    test_zero();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
